// File: rtl/context_issue.sv
// context_issue: per-PE context sequencer and operand issue stage feeding simple_alu.
// A small context memory is loaded while idle, then stepped cyclically at the
// configured initiation interval; operands come from PE inputs, the context
// constant or a result-feedback register, and every issue output is registered.
// Optional feature macro: CTX_PREDICATE_EN (adds a pred_en bit to each context
// word, drives op_predicate from in_b and squashes issues whose in_b is invalid).
module context_issue #(
  parameter int DATA_WIDTH = 16,
  parameter int CTX_DEPTH  = 16,
  localparam int CTX_AW    = $clog2(CTX_DEPTH),
`ifdef CTX_PREDICATE_EN
  localparam int CW        = DATA_WIDTH + 11
`else
  localparam int CW        = DATA_WIDTH + 10
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [CTX_AW-1:0]     cfg_addr,
  input  logic [CW-1:0]         cfg_wdata,
  output logic                  cfg_err,
  input  logic                  start,
  input  logic [CTX_AW:0]       ii,
  input  logic [15:0]           iter_count,
  input  logic                  stall,
  input  logic [DATA_WIDTH:0]   in_a,
  input  logic [DATA_WIDTH:0]   in_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  result_we,
  output logic [5:0]            operation,
  output logic [DATA_WIDTH:0]   op_RHS,
  output logic [DATA_WIDTH:0]   op_LHS,
  output logic [DATA_WIDTH:0]   op_SHIFT,
  output logic [DATA_WIDTH-1:0] op_predicate,
  output logic                  issue_valid,
  output logic [CTX_AW-1:0]     ctx_ptr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CTX_AW:0] II_MAX = (CTX_AW + 1)'(CTX_DEPTH);
  localparam logic [CTX_AW:0] II_ONE = (CTX_AW + 1)'(1);

  state_t                state_reg, state_next;
  logic [CTX_AW-1:0]     ctx_ptr_reg, ctx_ptr_next;
  logic [15:0]           iter_cnt_reg, iter_cnt_next;
  logic [CTX_AW:0]       ii_lat_reg, ii_lat_next;
  logic [15:0]           iter_lat_reg, iter_lat_next;
  logic                  last_reg, last_next;
  logic [5:0]            operation_reg, operation_next;
  logic [DATA_WIDTH:0]   rhs_reg, rhs_next;
  logic [DATA_WIDTH:0]   lhs_reg, lhs_next;
  logic [DATA_WIDTH:0]   shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] pred_reg, pred_next;
  logic                  issue_valid_reg, issue_valid_next;
  logic [DATA_WIDTH-1:0] fb_reg;
  logic                  fb_valid_reg;

  logic [CW-1:0]         ctx_mem [CTX_DEPTH];
  logic                  mem_we;
  logic [CW-1:0]         word;
  logic [5:0]            word_op;
  logic [1:0]            rhs_sel, lhs_sel;
  logic [DATA_WIDTH:0]   const_operand, fb_operand, rhs_value, lhs_value;
  logic [DATA_WIDTH-1:0] pred_value;
  logic                  issue_squash;
  logic [CTX_AW:0]       ii_clamped;
  logic [15:0]           iter_clamped;
  logic                  ptr_at_end, iter_at_end;

  // Configuration writes are only honoured while idle; anything else is flagged.
  assign mem_we  = cfg_we && (state_reg == IDLE);
  assign cfg_err = cfg_we && (state_reg != IDLE);

  // One write port per context entry; contents deliberately survive reset.
  generate
    for (genvar gi = 0; gi < CTX_DEPTH; gi++) begin : g_ctx
      always_ff @(posedge clock) begin
        if (mem_we && (cfg_addr == CTX_AW'(gi))) ctx_mem[gi] <= cfg_wdata;
      end
    end
  endgenerate

  // Decode the context word currently addressed by the sequencer.
  assign word          = ctx_mem[ctx_ptr_reg];
  assign word_op       = word[5:0];
  assign rhs_sel       = word[7:6];
  assign lhs_sel       = word[9:8];
  assign const_operand = {1'b1, word[DATA_WIDTH+9:10]};
  assign fb_operand    = {fb_valid_reg, fb_reg};

`ifdef CTX_PREDICATE_EN
  assign issue_squash = word[CW-1] && !in_b[DATA_WIDTH];
  assign pred_value   = word[CW-1] ? in_b[DATA_WIDTH-1:0] : '0;
`else
  assign issue_squash = 1'b0;
  assign pred_value   = '0;
`endif

  function automatic logic [DATA_WIDTH:0] pick_operand(
    input logic [1:0]          sel,
    input logic [DATA_WIDTH:0] a,
    input logic [DATA_WIDTH:0] b,
    input logic [DATA_WIDTH:0] c,
    input logic [DATA_WIDTH:0] f
  );
    case (sel)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return f;
    endcase
  endfunction

  // Operand muxes for the two selectable ALU inputs.
  always_comb begin
    rhs_value = pick_operand(rhs_sel, in_a, in_b, const_operand, fb_operand);
    lhs_value = pick_operand(lhs_sel, in_a, in_b, const_operand, fb_operand);
  end

  // Normalise the run parameters: zero means one, ii saturates at the memory depth.
  always_comb begin
    ii_clamped = ii;
    if (ii == '0)         ii_clamped = II_ONE;
    else if (ii > II_MAX) ii_clamped = II_MAX;
    iter_clamped = (iter_count == 16'd0) ? 16'd1 : iter_count;
  end

  assign ptr_at_end  = ({1'b0, ctx_ptr_reg} == (ii_lat_reg - II_ONE));
  assign iter_at_end = (iter_cnt_reg == (iter_lat_reg - 16'd1));

  // Sequencer next-state and issue-register next values.
  // last_reg marks that the final context has been issued, so DONE (and the
  // drop of issue_valid) lands one cycle after the last live issue.
  always_comb begin
    state_next       = state_reg;
    ctx_ptr_next     = ctx_ptr_reg;
    iter_cnt_next    = iter_cnt_reg;
    ii_lat_next      = ii_lat_reg;
    iter_lat_next    = iter_lat_reg;
    last_next        = last_reg;
    operation_next   = operation_reg;
    rhs_next         = rhs_reg;
    lhs_next         = lhs_reg;
    shift_next       = shift_reg;
    pred_next        = pred_reg;
    issue_valid_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = RUN;
          ctx_ptr_next  = '0;
          iter_cnt_next = 16'd0;
          last_next     = 1'b0;
          ii_lat_next   = ii_clamped;
          iter_lat_next = iter_clamped;
        end
      end
      RUN: begin
        if (last_reg) begin
          state_next     = DONE;
          operation_next = 6'd0;
        end else if (!stall) begin
          operation_next   = issue_squash ? 6'd0 : word_op;
          rhs_next         = rhs_value;
          lhs_next         = lhs_value;
          shift_next       = const_operand;
          pred_next        = pred_value;
          issue_valid_next = !issue_squash;
          if (ptr_at_end) begin
            ctx_ptr_next  = '0;
            iter_cnt_next = iter_cnt_reg + 16'd1;
            if (iter_at_end) last_next = 1'b1;
          end else begin
            ctx_ptr_next = ctx_ptr_reg + CTX_AW'(1);
          end
        end
      end
      DONE: begin
        state_next     = IDLE;
        operation_next = 6'd0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state and issue registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      ctx_ptr_reg     <= '0;
      iter_cnt_reg    <= 16'd0;
      ii_lat_reg      <= II_ONE;
      iter_lat_reg    <= 16'd1;
      last_reg        <= 1'b0;
      operation_reg   <= 6'd0;
      rhs_reg         <= '0;
      lhs_reg         <= '0;
      shift_reg       <= '0;
      pred_reg        <= '0;
      issue_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ctx_ptr_reg     <= ctx_ptr_next;
      iter_cnt_reg    <= iter_cnt_next;
      ii_lat_reg      <= ii_lat_next;
      iter_lat_reg    <= iter_lat_next;
      last_reg        <= last_next;
      operation_reg   <= operation_next;
      rhs_reg         <= rhs_next;
      lhs_reg         <= lhs_next;
      shift_reg       <= shift_next;
      pred_reg        <= pred_next;
      issue_valid_reg <= issue_valid_next;
    end
  end

  // Result feedback: a capture always wins over the clear that start performs.
  always_ff @(posedge clock) begin
    if (reset) begin
      fb_reg       <= '0;
      fb_valid_reg <= 1'b0;
    end else if (result_we) begin
      fb_reg       <= alu_result;
      fb_valid_reg <= 1'b1;
    end else if ((state_reg == IDLE) && start) begin
      fb_valid_reg <= 1'b0;
    end
  end

  assign operation    = operation_reg;
  assign op_RHS       = rhs_reg;
  assign op_LHS       = lhs_reg;
  assign op_SHIFT     = shift_reg;
  assign op_predicate = pred_reg;
  assign issue_valid  = issue_valid_reg;
  assign ctx_ptr      = ctx_ptr_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);

endmodule

// File: tb/tb_context_issue.sv
// Scoreboard bench for context_issue: stimulus pushes expected issues into a
// queue, a negedge monitor pops one entry per live issue and compares it.
module tb_context_issue;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef CTX_PREDICATE_EN
  localparam int CW      = DW + 11;
  localparam bit PRED_EN = 1'b1;
`else
  localparam int CW      = DW + 10;
  localparam bit PRED_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          cfg_err;
  logic          start;
  logic [AW:0]   ii;
  logic [15:0]   iter_count;
  logic          stall;
  logic [DW:0]   in_a, in_b;
  logic [DW-1:0] alu_result;
  logic          result_we;
  logic [5:0]    operation;
  logic [DW:0]   op_RHS, op_LHS, op_SHIFT;
  logic [DW-1:0] op_predicate;
  logic          issue_valid;
  logic [AW-1:0] ctx_ptr;
  logic          busy, done;

  context_issue #(.DATA_WIDTH(DW), .CTX_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .start(start), .ii(ii),
    .iter_count(iter_count), .stall(stall), .in_a(in_a), .in_b(in_b),
    .alu_result(alu_result), .result_we(result_we), .operation(operation),
    .op_RHS(op_RHS), .op_LHS(op_LHS), .op_SHIFT(op_SHIFT),
    .op_predicate(op_predicate), .issue_valid(issue_valid), .ctx_ptr(ctx_ptr),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]    op;
    logic [DW:0]   rhs;
    logic [DW:0]   lhs;
    logic [DW:0]   shift;
    logic [DW-1:0] pred;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   issue_cnt  = 0;
  int   txn        = 0;
  bit   mon_en     = 1'b1;

  // Reference copy of the context memory as written by the bench.
  logic [5:0]    m_op    [DEPTH];
  logic [1:0]    m_rhs   [DEPTH];
  logic [1:0]    m_lhs   [DEPTH];
  logic [DW-1:0] m_const [DEPTH];
  logic          m_pen   [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [DW:0] rhs, input logic [DW:0] lhs,
                          input logic [DW:0] shift, input logic [DW-1:0] pred);
    exp_t e;
    e.op = op; e.rhs = rhs; e.lhs = lhs; e.shift = shift; e.pred = pred;
    exp_q.push_back(e);
  endtask

  // Feedback is never selected by push_run users, so sel 3 is not modelled here.
  function automatic logic [DW:0] sel_op(input logic [1:0] sel, input logic [DW-1:0] cst);
    case (sel)
      2'd0:    return in_a;
      2'd1:    return in_b;
      default: return {1'b1, cst};
    endcase
  endfunction

  task automatic push_run(input int ii_eff, input int iters, output int n);
    bit pen;
    n = 0;
    for (int it = 0; it < iters; it++) begin
      for (int c = 0; c < ii_eff; c++) begin
        pen = PRED_EN && m_pen[c];
        if (!(pen && !in_b[DW])) begin
          push_exp(m_op[c], sel_op(m_rhs[c], m_const[c]), sel_op(m_lhs[c], m_const[c]),
                   {1'b1, m_const[c]}, pen ? in_b[DW-1:0] : '0);
          n++;
        end
      end
    end
  endtask

  // Monitor: one scoreboard pop per live issue.
  always @(negedge clock) begin
    if (!reset && issue_valid) begin
      issue_cnt++;
      if (mon_en) begin
        check("expected_available", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          txn++;
          $display("issue %0d: op=%h rhs=%h lhs=%h shift=%h pred=%h ptr=%0d",
                   txn, operation, op_RHS, op_LHS, op_SHIFT, op_predicate, ctx_ptr);
          check("issue_op",    32'(operation),    32'(mon_e.op));
          check("issue_rhs",   32'(op_RHS),       32'(mon_e.rhs));
          check("issue_lhs",   32'(op_LHS),       32'(mon_e.lhs));
          check("issue_shift", 32'(op_SHIFT),     32'(mon_e.shift));
          check("issue_pred",  32'(op_predicate), 32'(mon_e.pred));
        end
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic write_ctx(input int addr, input logic [5:0] op, input logic [1:0] rhs,
                           input logic [1:0] lhs, input logic [DW-1:0] cst, input logic pen);
    logic [CW-1:0] w;
    w = '0;
    w[5:0] = op; w[7:6] = rhs; w[9:8] = lhs; w[DW+9:10] = cst;
`ifdef CTX_PREDICATE_EN
    w[DW+10] = pen;
`endif
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = w;
    @(negedge clock);
    check("cfg_err_idle", 32'(cfg_err), 32'd0);
    @(posedge clock); #1;
    cfg_we = 1'b0;
    m_op[addr] = op; m_rhs[addr] = rhs; m_lhs[addr] = lhs; m_const[addr] = cst; m_pen[addr] = pen;
  endtask

  task automatic start_run(input logic [AW:0] ii_v, input logic [15:0] it_v);
    issue_cnt = 0;
    ii = ii_v; iter_count = it_v; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_n, input string tag);
    bit seen = 1'b0;
    bit prev_iv = issue_valid;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      else prev_iv = issue_valid;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_done_after_last_issue"}, 32'(prev_iv), 32'(exp_n > 0));
    check({tag, "_valid_low_in_done"}, 32'(issue_valid), 32'd0);
    check({tag, "_op_zero_in_done"}, 32'(operation), 32'd0);
    check({tag, "_issue_count"}, 32'(issue_cnt), 32'(exp_n));
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clock);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_single"}, 32'(done), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    int n;
    logic [CW-1:0] junk;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    ii = '0; iter_count = 16'd0; stall = 1'b0; in_a = '0; in_b = '0;
    alu_result = '0; result_we = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_operation", 32'(operation), 32'd0);
    check("rst_rhs", 32'(op_RHS), 32'd0);
    check("rst_lhs", 32'(op_LHS), 32'd0);
    check("rst_shift", 32'(op_SHIFT), 32'd0);
    check("rst_pred", 32'(op_predicate), 32'd0);
    check("rst_valid", 32'(issue_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ptr", 32'(ctx_ptr), 32'd0);
    @(posedge clock); #1;

    // Single context, three iterations, in_a={1,7}, const 5.
    write_ctx(0, 6'd1, 2'd0, 2'd2, 16'd5, 1'b0);
    in_a = 17'h10007; in_b = 17'h00009;
    repeat (3) push_exp(6'd1, 17'h10007, 17'h10005, 17'h10005, 16'h0000);
    start_run(5'd1, 16'd3);
    @(negedge clock);
    check("t1_no_issue_first_cycle", 32'(issue_valid), 32'd0);
    check("t1_busy_in_run", 32'(busy), 32'd1);
    @(negedge clock);
    check("t1_first_issue_latency", 32'(issue_valid), 32'd1);
    wait_done(3, "t1");

    // Three contexts, two iterations.
    write_ctx(0, 6'd2, 2'd1, 2'd2, 16'h0011, 1'b0);
    write_ctx(1, 6'd3, 2'd2, 2'd0, 16'h0022, 1'b0);
    write_ctx(2, 6'd4, 2'd0, 2'd1, 16'h0033, 1'b0);
    push_run(3, 2, n);
    start_run(5'd3, 16'd2);
    wait_done(n, "t2");

    // Two stalled cycles after the second issue.
    push_run(3, 2, n);
    start_run(5'd3, 16'd2);
    @(posedge clock);
    @(posedge clock); #1 stall = 1'b1;
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check("t3_stall1_valid", 32'(issue_valid), 32'd0);
    check("t3_stall1_ptr", 32'(ctx_ptr), 32'd2);
    check("t3_stall1_op", 32'(operation), 32'd3);
    check("t3_stall1_rhs", 32'(op_RHS), 32'h10022);
    @(posedge clock); #1 stall = 1'b0;
    @(negedge clock);
    check("t3_stall2_valid", 32'(issue_valid), 32'd0);
    check("t3_stall2_ptr", 32'(ctx_ptr), 32'd2);
    check("t3_stall2_lhs", 32'(op_LHS), 32'h10007);
    @(posedge clock); #1;
    wait_done(n, "t3");

    // Configuration write attempted mid-run is rejected.
    push_run(3, 1, n);
    start_run(5'd3, 16'd1);
    junk = '1;
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = junk;
    @(negedge clock);
    check("t4_cfg_err_run", 32'(cfg_err), 32'd1);
    @(posedge clock); #1 cfg_we = 1'b0;
    wait_done(n, "t4a");
    push_run(3, 1, n);
    start_run(5'd3, 16'd1);
    wait_done(n, "t4b");

    // Feedback operand: invalid until result_we, then carries the result.
    write_ctx(0, 6'd5, 2'd2, 2'd3, 16'h0001, 1'b0);
    push_exp(6'd5, 17'h10001, 17'h00000, 17'h10001, 16'h0000);
    push_exp(6'd5, 17'h10001, 17'h100AB, 17'h10001, 16'h0000);
    start_run(5'd1, 16'd2);
    result_we = 1'b1; alu_result = 16'h00AB;
    @(posedge clock); #1 result_we = 1'b0;
    wait_done(2, "t5a");
    // result_we together with start keeps the feedback valid.
    push_exp(6'd5, 17'h10001, 17'h100CD, 17'h10001, 16'h0000);
    result_we = 1'b1; alu_result = 16'h00CD;
    start_run(5'd1, 16'd1);
    result_we = 1'b0;
    wait_done(1, "t5b");
    // A plain start clears the valid tag but keeps the data.
    push_exp(6'd5, 17'h10001, 17'h000CD, 17'h10001, 16'h0000);
    start_run(5'd1, 16'd1);
    wait_done(1, "t5c");

    // ii=0 and iter_count=0 both behave as 1.
    write_ctx(0, 6'd1, 2'd0, 2'd2, 16'd5, 1'b0);
    push_exp(6'd1, 17'h10007, 17'h10005, 17'h10005, 16'h0000);
    start_run(5'd0, 16'd0);
    wait_done(1, "t6a");

    // ii above the memory depth saturates at 16 contexts.
    for (int i = 0; i < DEPTH; i++) write_ctx(i, 6'(i + 1), 2'd2, 2'd0, 16'(16'h0100 + i), 1'b0);
    push_run(16, 1, n);
    start_run(5'd20, 16'd1);
    wait_done(n, "t6b");

    // Predicated context: squashed while in_b invalid, predicate forwarded otherwise.
    write_ctx(0, 6'd6, 2'd0, 2'd2, 16'd3, 1'b1);
    in_b = 17'h00001;
    push_run(1, 1, n);
    start_run(5'd1, 16'd1);
    wait_done(n, "t7a");
    in_b = 17'h10001;
    push_run(1, 1, n);
    start_run(5'd1, 16'd1);
    wait_done(n, "t7b");

    // Reset in the middle of a long run.
    mon_en = 1'b0;
    start_run(5'd16, 16'd4);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("t8_busy", 32'(busy), 32'd0);
    check("t8_valid", 32'(issue_valid), 32'd0);
    check("t8_op", 32'(operation), 32'd0);
    check("t8_rhs", 32'(op_RHS), 32'd0);
    check("t8_lhs", 32'(op_LHS), 32'd0);
    check("t8_ptr", 32'(ctx_ptr), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("t8_no_done", 32'(done), 32'd0);
      @(negedge clock);
    end
    mon_en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
